// File: rtl/bpd_update_arbiter.sv
// N-channel branch-predictor update arbiter: mispredict class first, RR or fixed
// priority within a class, registered output FIFO. Optional: BPD_UPDATE_ARB_STATS_EN.
module bpd_update_arbiter #(
  parameter int N_IN  = 2,
  parameter int W     = 170,
  parameter int DEPTH = 2,
  parameter int RR    = 1,
  parameter int CW    = $clog2(N_IN)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_flush,
  input  logic [N_IN-1:0]   io_in_valid,
  output logic [N_IN-1:0]   io_in_ready,
  input  logic [N_IN-1:0]   io_in_mispredict,
  input  logic [N_IN*W-1:0] io_in_bits,
  output logic              io_out_valid,
  input  logic              io_out_ready,
  output logic [W-1:0]      io_out_bits,
  output logic [CW-1:0]     io_chosen
`ifdef BPD_UPDATE_ARB_STATS_EN
  ,
  output logic [31:0]       io_conflict_cnt
`endif
);

  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [W-1:0]    mem_bits   [DEPTH];
  logic [CW-1:0]   mem_chosen [DEPTH];
  logic [PW-1:0]   head, tail;
  logic [CNTW-1:0] count;
  logic [CW-1:0]   rr_ptr;

  logic [N_IN-1:0] hi, cand;
  logic [CW-1:0]   grant;
  logic            found;
  logic            enq_ready, enq, deq;
  logic [W-1:0]    enq_bits;

  assign hi   = io_in_valid & io_in_mispredict;
  assign cand = (hi != '0) ? hi : io_in_valid;

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    grant = '0;
    found = 1'b0;
    if (RR != 0) begin
      for (int k = 1; k <= N_IN; k++) begin
        if (!found && cand[(int'(rr_ptr) + k) % N_IN]) begin
          grant = CW'((int'(rr_ptr) + k) % N_IN);
          found = 1'b1;
        end
      end
    end else begin
      for (int i = N_IN - 1; i >= 0; i--) begin
        if (cand[i]) grant = CW'(i);
      end
    end
  end

  // Acceptance depends only on local state, never on io_out_ready; held off while in reset.
  assign enq_ready = (count < CNTW'(DEPTH)) & ~io_flush & ~reset;

  always_comb begin
    io_in_ready = '0;
    if ((cand != '0) && enq_ready) io_in_ready[grant] = 1'b1;
  end

  assign enq      = io_in_valid[grant] & io_in_ready[grant];
  assign enq_bits = io_in_bits[grant*W +: W];

  assign io_out_valid = (count != '0);
  assign deq          = io_out_valid & io_out_ready;
  assign io_out_bits  = mem_bits[head];
  assign io_chosen    = mem_chosen[head];

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      count  <= '0;
      head   <= '0;
      tail   <= '0;
      rr_ptr <= CW'(N_IN - 1);
      // NOTE: storage is cleared so io_out_bits/io_chosen read as zero out of reset.
      for (int i = 0; i < DEPTH; i++) begin
        mem_bits[i]   <= '0;
        mem_chosen[i] <= '0;
      end
    end else begin
      if (enq) begin
        mem_bits[tail]   <= enq_bits;
        mem_chosen[tail] <= grant;
        rr_ptr           <= grant;
      end
      if (io_flush) begin
        count <= '0;
        head  <= '0;
        tail  <= '0;
      end else begin
        if (enq) tail <= ptr_next(tail);
        if (deq) head <= ptr_next(head);
        case ({enq, deq})
          2'b10:   count <= count + CNTW'(1);
          2'b01:   count <= count - CNTW'(1);
          default: count <= count;
        endcase
      end
    end
  end

`ifdef BPD_UPDATE_ARB_STATS_EN
  // Counts accepted cycles that had competing requesters; survives flush.
  always_ff @(posedge clock) begin
    if (reset) begin
      io_conflict_cnt <= '0;
    end else if (enq && ($countones(io_in_valid) >= 2) && (io_conflict_cnt != 32'hFFFF_FFFF)) begin
      io_conflict_cnt <= io_conflict_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bpd_update_arbiter.sv
// Directed vector bench: one round-robin and one fixed-priority arbiter (N_IN=4, DEPTH=2)
// driven by the same stimulus; payload of channel c in vector v is {v, c}.
module tb_bpd_update_arbiter;

  localparam int N  = 4;
  localparam int WB = 16;
  localparam int NV = 25;

  logic            clock = 1'b0;
  logic            reset;
  logic            io_flush;
  logic [N-1:0]    io_in_valid, io_in_mispredict;
  logic [N*WB-1:0] io_in_bits;
  logic            io_out_ready;

  logic [N-1:0]    ready_a, ready_b;
  logic            ovalid_a, ovalid_b;
  logic [WB-1:0]   obits_a, obits_b;
  logic [1:0]      chosen_a, chosen_b;
`ifdef BPD_UPDATE_ARB_STATS_EN
  logic [31:0]     conf_a, conf_b;
`endif

  always #5 clock = ~clock;

  bpd_update_arbiter #(.N_IN(N), .W(WB), .DEPTH(2), .RR(1)) dut_a (
    .clock(clock), .reset(reset), .io_flush(io_flush),
    .io_in_valid(io_in_valid), .io_in_ready(ready_a), .io_in_mispredict(io_in_mispredict),
    .io_in_bits(io_in_bits), .io_out_valid(ovalid_a), .io_out_ready(io_out_ready),
    .io_out_bits(obits_a), .io_chosen(chosen_a)
`ifdef BPD_UPDATE_ARB_STATS_EN
    , .io_conflict_cnt(conf_a)
`endif
  );

  bpd_update_arbiter #(.N_IN(N), .W(WB), .DEPTH(2), .RR(0)) dut_b (
    .clock(clock), .reset(reset), .io_flush(io_flush),
    .io_in_valid(io_in_valid), .io_in_ready(ready_b), .io_in_mispredict(io_in_mispredict),
    .io_in_bits(io_in_bits), .io_out_valid(ovalid_b), .io_out_ready(io_out_ready),
    .io_out_bits(obits_b), .io_chosen(chosen_b)
`ifdef BPD_UPDATE_ARB_STATS_EN
    , .io_conflict_cnt(conf_b)
`endif
  );

  typedef struct {
    logic        flush;
    logic [3:0]  valid;
    logic [3:0]  misp;
    logic        oready;
    logic [3:0]  rdy_a;
    logic [3:0]  rdy_b;
    logic        ovalid;
    logic [1:0]  chosen;
    logic [15:0] obits;
  } vec_t;

  vec_t vt [NV];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic drive(input logic fl, input logic [3:0] v, input logic [3:0] m,
                       input logic ordy, input int tag);
    io_flush         = fl;
    io_in_valid      = v;
    io_in_mispredict = m;
    io_out_ready     = ordy;
    for (int c = 0; c < N; c++) io_in_bits[c*WB +: WB] = {8'(tag), 8'(c)};
  endtask

  initial begin
    //         flush valid misp  ordy rdyA  rdyB  oval ch    obits
    vt[0]  = '{1'b0, 4'hF, 4'h0, 1'b1, 4'h1, 4'h1, 1'b0, 2'd0, 16'h0000};
    vt[1]  = '{1'b0, 4'hF, 4'h0, 1'b1, 4'h2, 4'h1, 1'b1, 2'd0, 16'h0000};
    vt[2]  = '{1'b0, 4'hF, 4'h0, 1'b1, 4'h4, 4'h1, 1'b1, 2'd1, 16'h0101};
    vt[3]  = '{1'b0, 4'hF, 4'h0, 1'b1, 4'h8, 4'h1, 1'b1, 2'd2, 16'h0202};
    vt[4]  = '{1'b0, 4'hF, 4'h0, 1'b1, 4'h1, 4'h1, 1'b1, 2'd3, 16'h0303};
    vt[5]  = '{1'b0, 4'hF, 4'h0, 1'b1, 4'h2, 4'h1, 1'b1, 2'd0, 16'h0400};
    vt[6]  = '{1'b0, 4'hF, 4'h0, 1'b1, 4'h4, 4'h1, 1'b1, 2'd1, 16'h0501};
    vt[7]  = '{1'b0, 4'hF, 4'h0, 1'b1, 4'h8, 4'h1, 1'b1, 2'd2, 16'h0602};
    vt[8]  = '{1'b0, 4'h0, 4'h0, 1'b1, 4'h0, 4'h0, 1'b1, 2'd3, 16'h0703};
    vt[9]  = '{1'b0, 4'h5, 4'h4, 1'b1, 4'h4, 4'h4, 1'b0, 2'd0, 16'h0000};
    vt[10] = '{1'b0, 4'h1, 4'h0, 1'b1, 4'h1, 4'h1, 1'b1, 2'd2, 16'h0902};
    vt[11] = '{1'b0, 4'h6, 4'h4, 1'b1, 4'h4, 4'h4, 1'b1, 2'd0, 16'h0A00};
    vt[12] = '{1'b0, 4'h0, 4'h0, 1'b1, 4'h0, 4'h0, 1'b1, 2'd2, 16'h0B02};
    vt[13] = '{1'b0, 4'h2, 4'h0, 1'b0, 4'h2, 4'h2, 1'b0, 2'd0, 16'h0000};
    vt[14] = '{1'b0, 4'h2, 4'h0, 1'b0, 4'h2, 4'h2, 1'b1, 2'd1, 16'h0D01};
    vt[15] = '{1'b0, 4'h2, 4'h0, 1'b0, 4'h0, 4'h0, 1'b1, 2'd1, 16'h0D01};
    vt[16] = '{1'b0, 4'h2, 4'h0, 1'b1, 4'h0, 4'h0, 1'b1, 2'd1, 16'h0D01};
    vt[17] = '{1'b0, 4'h2, 4'h0, 1'b0, 4'h2, 4'h2, 1'b1, 2'd1, 16'h0E01};
    vt[18] = '{1'b0, 4'h2, 4'h0, 1'b1, 4'h0, 4'h0, 1'b1, 2'd1, 16'h0E01};
    vt[19] = '{1'b0, 4'h1, 4'h0, 1'b0, 4'h1, 4'h1, 1'b1, 2'd1, 16'h1101};
    vt[20] = '{1'b1, 4'h1, 4'h0, 1'b0, 4'h0, 4'h0, 1'b1, 2'd1, 16'h1101};
    vt[21] = '{1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 2'd0, 16'h0000};
    vt[22] = '{1'b0, 4'h3, 4'h0, 1'b1, 4'h2, 4'h1, 1'b0, 2'd0, 16'h0000};
    vt[23] = '{1'b0, 4'h3, 4'h0, 1'b1, 4'h1, 4'h1, 1'b1, 2'd1, 16'h1601};
    vt[24] = '{1'b0, 4'h0, 4'h0, 1'b1, 4'h0, 4'h0, 1'b1, 2'd0, 16'h1700};

    reset = 1'b1;
    drive(1'b0, 4'h0, 4'h0, 1'b0, 0);
    repeat (2) @(posedge clock);
    #1;
    check("reset out_valid", 32'(ovalid_a), 32'd0);
    check("reset out_bits",  32'(obits_a),  32'd0);
    check("reset chosen",    32'(chosen_a), 32'd0);
    drive(1'b0, 4'hF, 4'h0, 1'b1, 0);
    #1;
    check("reset in_ready",  32'(ready_a),  32'd0);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vt[i].flush, vt[i].valid, vt[i].misp, vt[i].oready, i);
      #3;
      check($sformatf("v%0d ready_a", i),  32'(ready_a),  32'(vt[i].rdy_a));
      check($sformatf("v%0d ready_b", i),  32'(ready_b),  32'(vt[i].rdy_b));
      check($sformatf("v%0d valid_a", i),  32'(ovalid_a), 32'(vt[i].ovalid));
      check($sformatf("v%0d valid_b", i),  32'(ovalid_b), 32'(vt[i].ovalid));
      if (vt[i].ovalid) begin
        check($sformatf("v%0d chosen_a", i), 32'(chosen_a), 32'(vt[i].chosen));
        check($sformatf("v%0d bits_a", i),   32'(obits_a),  32'(vt[i].obits));
      end
      if (i >= 1 && i <= 8) check($sformatf("v%0d chosen_b", i), 32'(chosen_b), 32'd0);
`ifdef BPD_UPDATE_ARB_STATS_EN
      if (i == 21) check("conflict after flush", conf_a, 32'd10);
`endif
      @(posedge clock);
      #1;
    end

`ifdef BPD_UPDATE_ARB_STATS_EN
    check("conflict total a", conf_a, 32'd12);
    check("conflict total b", conf_b, 32'd12);
`endif

    // Fill the FIFO, then reset mid-operation: contents and pointer state are lost.
    drive(1'b0, 4'h1, 4'h0, 1'b0, 30);
    repeat (2) @(posedge clock);
    #1;
    check("prefill out_valid", 32'(ovalid_a), 32'd1);
    check("prefill full",      32'(ready_a),  32'd0);
    reset = 1'b1;
    drive(1'b0, 4'hF, 4'h0, 1'b0, 31);
    #1;
    check("in reset in_ready", 32'(ready_a), 32'd0);
    @(posedge clock);
    #1;
    check("mid reset out_valid", 32'(ovalid_a), 32'd0);
    check("mid reset out_bits",  32'(obits_a),  32'd0);
    check("mid reset chosen",    32'(chosen_a), 32'd0);
    reset = 1'b0;
    #1;
    check("post reset rr grant", 32'(ready_a), 32'h1);
`ifdef BPD_UPDATE_ARB_STATS_EN
    check("post reset conflict", conf_a, 32'd0);
`endif
    @(posedge clock);
    #1;
    check("post reset rr next", 32'(ready_a), 32'h2);
    check("post reset head",    32'(obits_a), 32'h1F00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
